// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC flit widths, field positions and address extraction
package noc_pkg;

  localparam int DataWidthDef = 34;
  localparam int AddrWidthDef = 2;
  localparam int AddrMsbDef = DataWidthDef - 1;
  localparam int AddrLsbDef = DataWidthDef - AddrWidthDef;
  localparam int PayloadMsbDef = AddrLsbDef - 1;
  localparam int PayloadLsbDef = 0;

  // Upper bounds so one function serves every flit width in the network
  localparam int MaxFlitWidth = 64;
  localparam int MaxAddrWidth = 8;

  function automatic logic [MaxAddrWidth-1:0] flitAddr(
    input logic [MaxFlitWidth-1:0] flit,
    input int dataWidth,
    input int addrWidth
  );
    logic [MaxFlitWidth-1:0] shifted;
    logic [MaxAddrWidth-1:0] mask;
    shifted = flit >> (dataWidth - addrWidth);
    mask = (MaxAddrWidth'(1) << addrWidth) - MaxAddrWidth'(1);
    return shifted[MaxAddrWidth-1:0] & mask;
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// rtl/noc_fifo.sv - power-of-two depth valid/ready FIFO, readies gated by reset
module noc_fifo #(
  parameter int Width = 34,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [Width-1:0] pushData,
  input  logic             pushValid,
  output logic             pushReady,
  output logic [Width-1:0] popData,
  output logic             popValid,
  input  logic             popReady
);

  localparam int PtrWidth = $clog2(Depth);
  localparam int CntWidth = $clog2(Depth + 1);

  logic [Width-1:0]    mem [Depth];
  logic [PtrWidth-1:0] wrPtr;
  logic [PtrWidth-1:0] rdPtr;
  logic [CntWidth-1:0] count;
  logic                doPush;
  logic                doPop;

  // Full blocks a push even when a pop frees a slot in the same cycle
  assign pushReady = resetn && (count != CntWidth'(Depth));
  assign popValid  = resetn && (count != '0);
  assign popData   = mem[rdPtr];
  assign doPush    = pushValid && pushReady;
  assign doPop     = popValid && popReady;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushData;
        wrPtr <= wrPtr + 1'b1;
      end
      if (doPop) rdPtr <= rdPtr + 1'b1;
      if (doPush && !doPop) count <= count + 1'b1;
      else if (!doPush && doPop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pe_net_interface.sv
// rtl/pe_net_interface.sv - PE endpoint: TX flit queue to leaf switch, filtered RX buffer to PE
module pe_net_interface
  import noc_pkg::*;
#(
  parameter int DataWidth = DataWidthDef,
  parameter int AddrWidth = AddrWidthDef,
  parameter int MyAddr    = 0,
  parameter int TxDepth   = 4
) (
  input  logic                           i_sclk,
  input  logic                           i_reset,
  input  logic [DataWidth-AddrWidth-1:0] i_pe_tx_data,
  input  logic [AddrWidth-1:0]           i_pe_tx_dest,
  input  logic                           i_pe_tx_valid,
  output logic                           o_pe_tx_ready,
  output logic [DataWidth-1:0]           o_net_data,
  output logic                           o_net_data_valid,
  input  logic                           i_net_data_ready,
  input  logic [DataWidth-1:0]           i_net_data,
  input  logic                           i_net_data_valid,
  output logic                           o_net_data_ready,
  output logic [DataWidth-AddrWidth-1:0] o_pe_rx_data,
  output logic                           o_pe_rx_valid,
  input  logic                           i_pe_rx_ready,
  output logic                           o_misroute,
  output logic [15:0]                    o_tx_count,
  output logic [15:0]                    o_rx_count
);

  localparam int PayloadWidth = DataWidth - AddrWidth;

  logic addrMatch;
  logic netAccept;
  logic rxPushReady;

  noc_fifo #(.Width(DataWidth), .Depth(TxDepth)) txFifo (
    .clk      (i_sclk),
    .resetn   (i_reset),
    .pushData ({i_pe_tx_dest, i_pe_tx_data}),
    .pushValid(i_pe_tx_valid),
    .pushReady(o_pe_tx_ready),
    .popData  (o_net_data),
    .popValid (o_net_data_valid),
    .popReady (i_net_data_ready)
  );

  assign addrMatch = flitAddr(MaxFlitWidth'(i_net_data), DataWidth, AddrWidth)
                     == MaxAddrWidth'(MyAddr);
  assign o_net_data_ready = rxPushReady;
  assign netAccept = i_net_data_valid && rxPushReady;

  // Only flits for this endpoint are written; misaddressed flits are still consumed
  noc_fifo #(.Width(PayloadWidth), .Depth(2)) rxFifo (
    .clk      (i_sclk),
    .resetn   (i_reset),
    .pushData (i_net_data[PayloadWidth-1:0]),
    .pushValid(i_net_data_valid && addrMatch),
    .pushReady(rxPushReady),
    .popData  (o_pe_rx_data),
    .popValid (o_pe_rx_valid),
    .popReady (i_pe_rx_ready)
  );

  always_ff @(posedge i_sclk) begin
    if (!i_reset) begin
      o_misroute <= 1'b0;
      o_tx_count <= '0;
      o_rx_count <= '0;
    end else begin
      o_misroute <= netAccept && !addrMatch;
      if (o_net_data_valid && i_net_data_ready) o_tx_count <= o_tx_count + 16'd1;
      if (o_pe_rx_valid && i_pe_rx_ready) o_rx_count <= o_rx_count + 16'd1;
    end
  end

endmodule
